jtgng_dwnld: RTL
================

# jtgng_dwnld

ROM download sequencer that drives the game's ROM load port (romload_wr / romload_addr / romload_data) from a host byte stream with valid/ready handshake. It sits between the platform download interface and jtgng_game, paces writes so the ROM storage side can absorb them, and holds the game in reset until the image is complete. Its outputs connect directly to the romload_* inputs of the game block; romload_clk is tied to clk by the top level.

## Interface
Parameters:
- ROM_SIZE, 19'h50000, expected image length in bytes; addresses 0..ROM_SIZE-1 are written.
- WR_GAP, 4, idle cycles after each write strobe before the next byte is accepted (range 0..15).
- RST_HOLD, 16, cycles game_rst stays high after end of download (range 1..255).

Ports:
- clk  in  1  system clock, 24 MHz.
- rst  in  1  asynchronous, active-high reset.
- dl_start  in  1  one-cycle pulse: begin a new download at address 0.
- dl_end  in  1  one-cycle pulse: host has sent the last byte.
- dl_valid  in  1  dl_data holds a byte.
- dl_data  in  8  download byte.
- dl_ready  out  1  block accepts a byte this cycle.
- romload_wr  out  1  one-cycle write strobe.
- romload_addr  out  19  byte address.
- romload_data  out  8  byte data.
- game_rst  out  1  hold game in reset.
- downloading  out  1  high from dl_start until HOLD exits.
- done  out  1  image loaded, game released.
- overflow  out  1  sticky: byte received with count == ROM_SIZE.
- short  out  1  sticky: dl_end with count < ROM_SIZE.
- cksum  out  16  running byte sum (see Configuration).

## Operation
- Internal byte count cnt (19 bit); end_pend flag.
- States: IDLE, ACCEPT, WRITE, GAP, HOLD, DONE.
- IDLE: dl_ready=0, game_rst=1. dl_start -> ACCEPT.
- ACCEPT: dl_ready=1. dl_valid: if cnt < ROM_SIZE, romload_data<=dl_data, romload_addr<=cnt, -> WRITE; else byte dropped, overflow<=1, stay. dl_end (or end_pend) with no valid byte -> HOLD, short<=(cnt<ROM_SIZE).
- WRITE: romload_wr=1 for exactly one cycle, cnt<=cnt+1; -> GAP if WR_GAP>0 else ACCEPT.
- GAP: dl_ready=0 for WR_GAP cycles, then ACCEPT.
- dl_end arriving in WRITE/GAP, or together with an accepted byte: end_pend<=1, processed on return to ACCEPT after the byte is written.
- HOLD: game_rst=1, dl_ready=0, count RST_HOLD cycles -> DONE.
- DONE: game_rst=0, done=1, downloading=0. dl_start -> ACCEPT.
- dl_start in any state has priority: cnt<=0, end_pend, overflow, short, cksum cleared, game_rst=1, done=0, -> ACCEPT; an in-flight WRITE strobe in that cycle is suppressed.
- dl_valid/dl_data ignored outside ACCEPT; dl_end ignored in IDLE, HOLD, DONE.

## Timing
- Reset values: state IDLE, dl_ready=0, romload_wr=0, romload_addr=0, romload_data=0, game_rst=1, downloading=0, done=0, overflow=0, short=0, cksum=0, cnt=0.
- Byte accepted on edge N (dl_valid & dl_ready) -> romload_wr high in cycle N+1 with addr/data valid; addr/data held until next accept.
- Throughput: one byte per WR_GAP+2 cycles; dl_ready deasserted during WRITE and GAP.
- Last write to game_rst falling: RST_HOLD+1 cycles after HOLD entry; done rises same edge game_rst falls.
- All outputs registered.

## Configuration
- JTGNG_DWNLD_CKSUM_EN defined: cksum is a 16-bit wrap-around sum of every byte strobed by romload_wr (dropped overflow bytes excluded), updated the cycle after WRITE, cleared by dl_start.
- Not defined: cksum tied to 16'd0, no adder logic.

## Test plan
- Reset mid-WRITE: assert rst -> all outputs at reset values same cycle, no further romload_wr.
- ROM_SIZE=8, WR_GAP=2, dl_start then bytes 0x01..0x08, dl_end -> 8 strobes at addr 0..7, 4 cycles apart, short=0, overflow=0, done after 17 cycles in HOLD (RST_HOLD=16), cksum=0x0024 with macro.
- ROM_SIZE=4, send 6 bytes -> 4 strobes, overflow=1, bytes 5-6 not written.
- ROM_SIZE=8, send 3 bytes, dl_end -> short=1, done still reached, game_rst released.
- dl_end in the same cycle as last byte accepted -> byte written at correct address before HOLD entry.
- dl_start in GAP after 5 bytes -> next byte written at addr 0, cksum reset, game_rst stays 1.

Source files
------------

// File: rtl/jtgng_dwnld.sv
// jtgng_dwnld: paces a host byte stream into the game ROM load port and holds the game in reset until the image is loaded
// Optional feature: define JTGNG_DWNLD_CKSUM_EN for a 16-bit running byte sum on cksum (tied to zero otherwise).
// Ports: clk, rst (async, active high); dl_start/dl_end/dl_valid/dl_data/dl_ready host side;
// romload_wr/romload_addr/romload_data game ROM side; game_rst, downloading, done, overflow, short, cksum status.
module jtgng_dwnld #(
  parameter logic [18:0] ROM_SIZE = 19'h50000,
  parameter int WR_GAP = 4,
  parameter int RST_HOLD = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dl_start,
  input  logic        dl_end,
  input  logic        dl_valid,
  input  logic [7:0]  dl_data,
  output logic        dl_ready,
  output logic        romload_wr,
  output logic [18:0] romload_addr,
  output logic [7:0]  romload_data,
  output logic        game_rst,
  output logic        downloading,
  output logic        done,
  output logic        overflow,
  output logic        short,
  output logic [15:0] cksum
);
  typedef enum logic [2:0] {IDLE, ACCEPT, WRITE, GAP, HOLD, DONE} state_t;
  localparam logic [3:0] GAP_LAST = 4'(WR_GAP - 1);
  localparam logic [7:0] HOLD_LAST = 8'(RST_HOLD);
  state_t st, nx;
  logic [18:0] cnt;
  logic [3:0] gc;
  logic [7:0] hc;
  logic end_pend, in_acc, room, fin;
  assign in_acc = st == ACCEPT;
  assign room = cnt < ROM_SIZE;
  // end is only honoured once no byte is pending, so a byte sent with dl_end is written first
  assign fin = in_acc && !dl_valid && (dl_end || end_pend);
  always_comb begin
    nx = st;
    case (st)
      IDLE:    nx = IDLE;
      ACCEPT:  nx = dl_valid ? (room ? WRITE : ACCEPT) : (fin ? HOLD : ACCEPT);
      WRITE:   nx = WR_GAP > 0 ? GAP : ACCEPT;
      GAP:     nx = gc == GAP_LAST ? ACCEPT : GAP;
      HOLD:    nx = hc == HOLD_LAST ? DONE : HOLD;
      DONE:    nx = DONE;
      default: nx = IDLE;
    endcase
    if (dl_start) nx = ACCEPT;
  end
  // outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      dl_ready <= 1'b0;
      romload_wr <= 1'b0;
      romload_addr <= '0;
      romload_data <= '0;
      game_rst <= 1'b1;
      downloading <= 1'b0;
      done <= 1'b0;
      overflow <= 1'b0;
      short <= 1'b0;
      cnt <= '0;
      gc <= '0;
      hc <= '0;
      end_pend <= 1'b0;
    end else begin
      st <= nx;
      dl_ready <= nx == ACCEPT;
      romload_wr <= nx == WRITE;
      game_rst <= nx != DONE;
      done <= nx == DONE;
      downloading <= nx != IDLE && nx != DONE;
      gc <= st == GAP ? gc + 4'd1 : 4'd0;
      hc <= st == HOLD ? hc + 8'd1 : 8'd0;
      if (dl_start) begin
        cnt <= '0;
        end_pend <= 1'b0;
        overflow <= 1'b0;
        short <= 1'b0;
      end else begin
        if (in_acc && dl_valid && room) begin
          romload_addr <= cnt;
          romload_data <= dl_data;
        end
        if (in_acc && dl_valid && !room) overflow <= 1'b1;
        if (st == WRITE) cnt <= cnt + 19'd1;
        if (fin) begin
          end_pend <= 1'b0;
          short <= room;
        end else if (dl_end && (in_acc || st == WRITE || st == GAP)) end_pend <= 1'b1;
      end
    end
  end
`ifdef JTGNG_DWNLD_CKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cksum <= '0;
    else if (dl_start) cksum <= '0;
    else if (romload_wr) cksum <= cksum + {8'd0, romload_data};
  end
`else
  assign cksum = 16'd0;
`endif
endmodule
